vocab_scan_ctrl: RTL and testbench
==================================

VOCAB_SCAN_CTRL -- requirements
Module: vocab_scan_ctrl

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 4: vocab RAM address width.
REQ-002 SHALL have parameter WORD_LENGTH, default 3: characters per vocab entry.
REQ-003 SHALL have parameter DATA_WIDTH, default 8: bits per character; entry width W = WORD_LENGTH*DATA_WIDTH.
REQ-004 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-005 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port start  input  1  scan request, sampled in IDLE only.
REQ-007 SHALL have port abort  input  1  cancel the current scan.
REQ-008 SHALL have port word  input  W  search key, latched on accepted start.
REQ-009 SHALL have port start_addr  input  ADDR_WIDTH  first entry to scan, latched on accepted start.
REQ-010 SHALL have port end_addr  input  ADDR_WIDTH  last entry to scan, latched on accepted start.
REQ-011 SHALL have port ram_en  output  1  vocab RAM read enable.
REQ-012 SHALL have port ram_addr  output  ADDR_WIDTH  vocab RAM read address.
REQ-013 SHALL have port ram_dout  input  W  vocab RAM data, valid exactly one cycle after ram_en.
REQ-014 SHALL have port busy  output  1  scan in progress.
REQ-015 SHALL have port done  output  1  one-cycle completion pulse.
REQ-016 SHALL have port found  output  1  result: key matched.
REQ-017 SHALL have port match_addr  output  ADDR_WIDTH  result: address of the matching or terminating entry.
REQ-018 SHALL have port overflow  output  1  result: scan address wrapped from 2^ADDR_WIDTH-1 to 0.
REQ-019 SHALL have port null_hit  output  1  result: scan stopped on an all-zero (null) entry.

Function
REQ-020 SHALL implement FSM states IDLE, FETCH, CHECK, DONE.
REQ-021 SHALL, in IDLE with start=1, latch word/start_addr/end_addr, load curr_addr=start_addr, clear found/overflow/null_hit/match_addr, and go to FETCH.
REQ-022 SHALL, in FETCH, drive ram_en=1 and ram_addr=curr_addr for that cycle only, then go to CHECK.
REQ-023 SHALL, in CHECK, compare the full W-bit ram_dout with the latched word, with priority match > null > end-of-range > continue.
REQ-024 SHALL, on a match, set found=1 and match_addr=curr_addr, then go to DONE.
REQ-025 SHALL, on ram_dout==0 with no match, set null_hit=1 and match_addr=curr_addr, then go to DONE; an all-zero key therefore reports found=1, not null_hit.
REQ-026 SHALL, when curr_addr==end_addr with no match and no null, set found=0 and match_addr=end_addr, then go to DONE.
REQ-027 SHALL, otherwise, increment curr_addr modulo 2^ADDR_WIDTH, set overflow=1 if the increment wraps from all-ones to 0, and return to FETCH.
REQ-028 SHALL treat start_addr>end_addr as a wrapping scan; start_addr==end_addr SHALL scan exactly one entry.
REQ-029 SHALL, in DONE, pulse done=1 for one cycle and return to IDLE.
REQ-030 SHALL drive busy=1 in FETCH and CHECK, and busy=0 in IDLE and DONE.
REQ-031 SHALL hold found/match_addr/overflow/null_hit stable from DONE until the next accepted start.
REQ-032 SHALL ignore start outside IDLE, including start in the DONE cycle.
REQ-033 SHALL, on abort=1 in FETCH or CHECK, go to IDLE next cycle with no done pulse and results cleared to 0; abort has priority over CHECK results; abort in IDLE/DONE SHALL have no effect.
REQ-034 SHALL give latency 3+2k cycles from the start-sampling edge to the done cycle, where k is the number of entries scanned before the terminating one.
REQ-035 SHALL drive ram_addr=0 whenever ram_en=0.

Reset
REQ-036 SHALL, on rst_n=0, asynchronously enter IDLE and drive ram_en=0, ram_addr=0, busy=0, done=0, found=0, match_addr=0, overflow=0, null_hit=0.
REQ-037 SHALL, on reset during a scan, discard the scan entirely, and SHALL need a fresh start after reset release.

Verification
REQ-038 SHALL pass: RAM[5]=24'h48656C, RAM[0..4] nonzero non-matching, word=24'h48656C, start 0..15 -> done at cycle 13, found=1, match_addr=5, overflow=0, null_hit=0.
REQ-039 SHALL pass: RAM[3]=0, RAM[0..2] nonzero non-matching, word=24'h48656C, range 0..15 -> done at cycle 9, null_hit=1, found=0, match_addr=3.
REQ-040 SHALL pass: key only at RAM[1], all entries nonzero, range 14..1 -> ram_addr sequence 14,15,0,1, overflow=1, found=1, match_addr=1.
REQ-041 SHALL pass: key absent, no null, range 2..4 -> done at cycle 7, found=0, match_addr=4, null_hit=0.
REQ-042 SHALL pass: abort asserted in the second CHECK cycle -> IDLE next cycle, no done pulse, all results 0; start asserted while busy -> ignored.
REQ-043 SHALL pass: rst_n low mid-scan -> all outputs 0 immediately, no done pulse after release until a new start.

Source files
------------

// File: rtl/vocab_scan_ctrl.sv
// vocab_scan_ctrl: linear scan of a vocabulary RAM for a search key.
// Each entry is WORD_LENGTH*DATA_WIDTH bits wide. The scan walks from
// start_addr to end_addr and wraps past the top of the address space if
// needed. It stops on the first entry that matches the key, on the first
// all-zero (null) entry, or after it has checked end_addr. The RAM has
// one cycle of read latency, so every entry costs a FETCH cycle and a
// CHECK cycle.
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_IDLE  | waiting for start; results of the last scan are held
// S_FETCH | read request for curr_addr issued to the RAM
// S_CHECK | RAM word compared against the key; stop or advance
// S_DONE  | one-cycle done pulse, then back to S_IDLE
module vocab_scan_ctrl #(
    parameter int ADDR_WIDTH  = 4,
    parameter int WORD_LENGTH = 3,
    parameter int DATA_WIDTH  = 8
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              start,
    input  logic                              abort,
    input  logic [WORD_LENGTH*DATA_WIDTH-1:0] word,
    input  logic [ADDR_WIDTH-1:0]             start_addr,
    input  logic [ADDR_WIDTH-1:0]             end_addr,
    output logic                              ram_en,
    output logic [ADDR_WIDTH-1:0]             ram_addr,
    input  logic [WORD_LENGTH*DATA_WIDTH-1:0] ram_dout,
    output logic                              busy,
    output logic                              done,
    output logic                              found,
    output logic [ADDR_WIDTH-1:0]             match_addr,
    output logic                              overflow,
    output logic                              null_hit
);

    localparam int W = WORD_LENGTH * DATA_WIDTH;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_CHECK = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t                r_state;
    state_t                w_next_state;

    logic [W-1:0]          r_word;
    logic [ADDR_WIDTH-1:0] r_end_addr;
    logic [ADDR_WIDTH-1:0] r_curr_addr;
    logic                  r_found;
    logic [ADDR_WIDTH-1:0] r_match_addr;
    logic                  r_overflow;
    logic                  r_null_hit;

    logic                  w_accept;
    logic                  w_abort;
    logic                  w_hit;
    logic                  w_null;
    logic                  w_last;
    logic                  w_wrap;

    // start is only looked at in IDLE; abort only acts while a scan is active
    assign w_accept = (r_state == S_IDLE) && start;
    assign w_abort  = abort && ((r_state == S_FETCH) || (r_state == S_CHECK));

    // A key match wins over a null entry, so an all-zero key reports found
    assign w_hit  = (ram_dout == r_word);
    assign w_null = (ram_dout == '0);
    assign w_last = (r_curr_addr == r_end_addr);
    assign w_wrap = &r_curr_addr;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state decode; abort overrides whatever CHECK would have concluded
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_next_state = S_FETCH;
                end
            end
            S_FETCH: begin
                if (abort) begin
                    w_next_state = S_IDLE;
                end else begin
                    w_next_state = S_CHECK;
                end
            end
            S_CHECK: begin
                if (abort) begin
                    w_next_state = S_IDLE;
                end else if (w_hit || w_null || w_last) begin
                    w_next_state = S_DONE;
                end else begin
                    w_next_state = S_FETCH;
                end
            end
            S_DONE: begin
                w_next_state = S_IDLE;
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    // Moore outputs; the address bus is parked at zero when no read is issued
    always_comb begin
        ram_en   = 1'b0;
        ram_addr = '0;
        busy     = 1'b0;
        done     = 1'b0;
        case (r_state)
            S_FETCH: begin
                ram_en   = 1'b1;
                ram_addr = r_curr_addr;
                busy     = 1'b1;
            end
            S_CHECK: begin
                busy = 1'b1;
            end
            S_DONE: begin
                done = 1'b1;
            end
            default: begin
                ram_en = 1'b0;
            end
        endcase
    end

    // Request latch and scan address: these are captured when a start is accepted
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_word      <= '0;
            r_end_addr  <= '0;
            r_curr_addr <= '0;
        end else if (w_accept) begin
            r_word      <= word;
            r_end_addr  <= end_addr;
            r_curr_addr <= start_addr;
        end else if ((r_state == S_CHECK) && !abort && !w_hit && !w_null && !w_last) begin
            r_curr_addr <= r_curr_addr + 1'b1;
        end
    end

    // Result registers: cleared on start or abort, updated when the scan ends
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_found      <= 1'b0;
            r_match_addr <= '0;
            r_overflow   <= 1'b0;
            r_null_hit   <= 1'b0;
        end else if (w_accept || w_abort) begin
            r_found      <= 1'b0;
            r_match_addr <= '0;
            r_overflow   <= 1'b0;
            r_null_hit   <= 1'b0;
        end else if (r_state == S_CHECK) begin
            if (w_hit) begin
                r_found      <= 1'b1;
                r_match_addr <= r_curr_addr;
            end else if (w_null) begin
                r_null_hit   <= 1'b1;
                r_match_addr <= r_curr_addr;
            end else if (w_last) begin
                r_found      <= 1'b0;
                r_match_addr <= r_end_addr;
            end else if (w_wrap) begin
                r_overflow   <= 1'b1;
            end
        end
    end

    assign found      = r_found;
    assign match_addr = r_match_addr;
    assign overflow   = r_overflow;
    assign null_hit   = r_null_hit;

endmodule

// File: tb/tb_vocab_scan_ctrl.sv
// Bench for vocab_scan_ctrl: a behavioural RAM, a scan model that walks
// the address ring, and a negedge compare process that checks every
// output on every cycle.
module tb_vocab_scan_ctrl;

    localparam int AW  = 4;
    localparam int W   = 24;
    localparam int NE  = 1 << AW;
    localparam logic [W-1:0] KEY = 24'h48656C;

    logic          clk;
    logic          rst_n;
    logic          start;
    logic          abort;
    logic [W-1:0]  word;
    logic [AW-1:0] start_addr;
    logic [AW-1:0] end_addr;
    logic          ram_en;
    logic [AW-1:0] ram_addr;
    logic [W-1:0]  ram_dout;
    logic          busy;
    logic          done;
    logic          found;
    logic [AW-1:0] match_addr;
    logic          overflow;
    logic          null_hit;

    vocab_scan_ctrl #(.ADDR_WIDTH(AW), .WORD_LENGTH(3), .DATA_WIDTH(8)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .word(word),
        .start_addr(start_addr), .end_addr(end_addr), .ram_en(ram_en),
        .ram_addr(ram_addr), .ram_dout(ram_dout), .busy(busy), .done(done),
        .found(found), .match_addr(match_addr), .overflow(overflow),
        .null_hit(null_hit)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // RAM: data valid only the cycle after ram_en; noise otherwise
    logic [W-1:0] mem [NE];
    always @(posedge clk) begin
        if (ram_en) ram_dout <= mem[ram_addr];
        else        ram_dout <= W'($urandom);
    end

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", nm, act, exp, $time);
        end
    endtask

    // expected outputs for the current cycle
    bit            chk_en = 0;
    logic          e_en, e_busy, e_done, e_found, e_ovf, e_nul, e_ovf_chk;
    logic [AW-1:0] e_addr, e_maddr;
    logic          p_found, p_ovf, p_nul;
    logic [AW-1:0] p_maddr;

    always @(negedge clk) begin
        if (chk_en) begin
            chk("ram_en", 32'(ram_en), 32'(e_en));
            chk("ram_addr", 32'(ram_addr), 32'(e_addr));
            chk("busy", 32'(busy), 32'(e_busy));
            chk("done", 32'(done), 32'(e_done));
            chk("found", 32'(found), 32'(e_found));
            chk("match_addr", 32'(match_addr), 32'(e_maddr));
            chk("null_hit", 32'(null_hit), 32'(e_nul));
            if (e_ovf_chk) chk("overflow", 32'(overflow), 32'(e_ovf));
        end
    end

    task automatic exp_idle(input logic d, input logic f, input logic [AW-1:0] ma,
                            input logic o, input logic n);
        e_en = 0; e_addr = 0; e_busy = 0; e_done = d;
        e_found = f; e_maddr = ma; e_ovf = o; e_nul = n; e_ovf_chk = 1;
    endtask

    task automatic exp_scan(input logic en, input logic [AW-1:0] a);
        e_en = en; e_addr = a; e_busy = 1; e_done = 0;
        e_found = 0; e_maddr = 0; e_ovf = 0; e_nul = 0; e_ovf_chk = 0;
    endtask

    // scan model: walk the ring of addresses from sa and stop on the rules
    int            m_k;
    logic          m_found, m_ovf, m_nul;
    logic [AW-1:0] m_maddr;
    logic [AW-1:0] m_seq [$];

    task automatic model(input logic [W-1:0] key, input logic [AW-1:0] sa, input logic [AW-1:0] ea);
        int a;
        a = int'(sa);
        m_k = 0; m_found = 0; m_ovf = 0; m_nul = 0; m_maddr = 0;
        m_seq.delete();
        for (int i = 0; i < NE; i++) begin
            m_seq.push_back(AW'(a));
            if (mem[a] == key) begin m_found = 1; m_maddr = AW'(a); break; end
            if (mem[a] == 0)   begin m_nul = 1;   m_maddr = AW'(a); break; end
            if (a == int'(ea)) begin m_maddr = AW'(a); break; end
            if (a + 1 == NE) m_ovf = 1;
            a = (a + 1) % NE;
            m_k++;
        end
    endtask

    function automatic logic [W-1:0] rand_entry(input logic [W-1:0] key);
        logic [W-1:0] v;
        v = W'($urandom);
        while (v == 0 || v == key) v = W'($urandom);
        return v;
    endfunction

    task automatic fill(input logic [W-1:0] key);
        for (int i = 0; i < NE; i++) mem[i] = rand_entry(key);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            start = 0; abort = 1'($urandom_range(0, 1));
            exp_idle(0, p_found, p_maddr, p_ovf, p_nul);
        end
    endtask

    // ab: 0 = no abort, -1 = random cycle, >0 = abort in that scan cycle
    task automatic run_scan(input logic [W-1:0] key, input logic [AW-1:0] sa,
                            input logic [AW-1:0] ea, input int ab_in);
        int L, ab;
        model(key, sa, ea);
        L  = 3 + 2 * m_k;
        ab = (ab_in < 0) ? int'($urandom_range(1, L - 1)) : ab_in;
        word = key; start_addr = sa; end_addr = ea;
        start = 1; abort = 1'($urandom_range(0, 1));
        exp_idle(0, p_found, p_maddr, p_ovf, p_nul);
        for (int c = 1; c <= L; c++) begin
            @(posedge clk); #1;
            start = 1'($urandom_range(0, 1));
            word = W'($urandom); start_addr = AW'($urandom); end_addr = AW'($urandom);
            abort = (c == ab) ? 1'b1 : ((c == L) ? 1'($urandom_range(0, 1)) : 1'b0);
            if (c == L)          exp_idle(1, m_found, m_maddr, m_ovf, m_nul);
            else if (c % 2 == 1) exp_scan(1, m_seq[(c - 1) / 2]);
            else                 exp_scan(0, 0);
            if (c == ab) begin
                @(posedge clk); #1;
                start = 0; abort = 0;
                p_found = 0; p_maddr = 0; p_ovf = 0; p_nul = 0;
                exp_idle(0, 0, 0, 0, 0);
                return;
            end
        end
        @(posedge clk); #1;
        start = 0; abort = 0;
        p_found = m_found; p_maddr = m_maddr; p_ovf = m_ovf; p_nul = m_nul;
        exp_idle(0, p_found, p_maddr, p_ovf, p_nul);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_ram_en"}, 32'(ram_en), 0);
        chk({tag, "_ram_addr"}, 32'(ram_addr), 0);
        chk({tag, "_busy"}, 32'(busy), 0);
        chk({tag, "_done"}, 32'(done), 0);
        chk({tag, "_found"}, 32'(found), 0);
        chk({tag, "_match_addr"}, 32'(match_addr), 0);
        chk({tag, "_overflow"}, 32'(overflow), 0);
        chk({tag, "_null_hit"}, 32'(null_hit), 0);
    endtask

    initial begin
        logic [W-1:0] key;
        int r;
        rst_n = 1; start = 0; abort = 0; word = 0; start_addr = 0; end_addr = 0;
        p_found = 0; p_maddr = 0; p_ovf = 0; p_nul = 0;
        fill(KEY);
        #1 rst_n = 0;
        #1 chk_all_zero("reset");
        @(posedge clk); #1;
        rst_n = 1;
        exp_idle(0, 0, 0, 0, 0);
        chk_en = 1;
        idle(2);

        // key at 5, full range
        fill(KEY); mem[5] = KEY;
        run_scan(KEY, 0, 15, 0);
        chk("pin_hit_latency", 32'(3 + 2 * m_k), 13);
        chk("pin_hit_found", 32'(m_found), 1);
        chk("pin_hit_addr", 32'(m_maddr), 5);
        idle(2);

        // null entry at 3
        fill(KEY); mem[3] = 0;
        run_scan(KEY, 0, 15, 0);
        chk("pin_null_latency", 32'(3 + 2 * m_k), 9);
        chk("pin_null_flag", 32'(m_nul), 1);
        chk("pin_null_addr", 32'(m_maddr), 3);

        // wrapping range 14..1, key at 1
        fill(KEY); mem[1] = KEY;
        run_scan(KEY, 14, 1, 0);
        chk("pin_wrap_len", 32'(m_seq.size()), 4);
        chk("pin_wrap_seq0", 32'(m_seq[0]), 14);
        chk("pin_wrap_seq1", 32'(m_seq[1]), 15);
        chk("pin_wrap_seq2", 32'(m_seq[2]), 0);
        chk("pin_wrap_seq3", 32'(m_seq[3]), 1);
        chk("pin_wrap_ovf", 32'(m_ovf), 1);

        // key absent, range 2..4
        fill(KEY);
        run_scan(KEY, 2, 4, 0);
        chk("pin_miss_latency", 32'(3 + 2 * m_k), 7);
        chk("pin_miss_addr", 32'(m_maddr), 4);
        chk("pin_miss_found", 32'(m_found), 0);
        idle(1);

        // abort in the second CHECK cycle
        fill(KEY); mem[5] = KEY;
        run_scan(KEY, 0, 15, 4);
        idle(2);

        // single entry, all-zero key, range ending at the top with no wrap
        fill(KEY);
        run_scan(KEY, 7, 7, 0);
        chk("pin_single_latency", 32'(3 + 2 * m_k), 3);
        fill(KEY); mem[2] = 0;
        run_scan('0, 0, 15, 0);
        chk("pin_zero_key_found", 32'(m_found), 1);
        chk("pin_zero_key_null", 32'(m_nul), 0);
        fill(KEY);
        run_scan(KEY, 12, 15, 0);
        chk("pin_top_ovf", 32'(m_ovf), 0);

        // reset in the middle of a scan
        fill(KEY); mem[5] = KEY;
        chk_en = 0;
        word = KEY; start_addr = 0; end_addr = 15; start = 1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            start = 0;
        end
        rst_n = 0;
        #1 chk_all_zero("midscan_reset");
        @(posedge clk); #1;
        rst_n = 1;
        p_found = 0; p_maddr = 0; p_ovf = 0; p_nul = 0;
        exp_idle(0, 0, 0, 0, 0);
        chk_en = 1;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            start = 0; abort = 0;
        end

        // randomized scans
        for (int t = 0; t < 60; t++) begin
            key = ($urandom_range(0, 9) == 0) ? '0 : W'($urandom);
            for (int i = 0; i < NE; i++) begin
                r = int'($urandom_range(0, 99));
                if (r < 8)       mem[i] = 0;
                else if (r < 16) mem[i] = key;
                else             mem[i] = rand_entry(key);
            end
            run_scan(key, AW'($urandom), AW'($urandom),
                     ($urandom_range(0, 4) == 0) ? -1 : 0);
            if ($urandom_range(0, 2) == 0) idle(int'($urandom_range(1, 3)));
        end

        idle(2);
        chk_en = 0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
